mips_ctrl_decoder: RTL and testbench

- Single-cycle-latency control decoder for the pipelined MIPS core; merges main (opcode) decode and auxiliary (funct) decode into one block.
- Produces decode-stage (D) branch/jump/jal/jr/illegal combinationally.
- Registers the 13-bit datapath control bundle into an execute-stage (E) register with a hazard-unit flush.

---
 rtl/mips_ctrl_decoder_if.sv | 35 +++
 rtl/mips_ctrl_decoder.sv | 138 +++++++++++++
 tb/tb_mips_ctrl_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_decoder_if.sv
// Decode-stage instruction fields in, D-stage flags and E-stage control bundle out.
interface mips_ctrl_decoder_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       flush_e;
    logic       branch;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       illegal;
    logic       reg_dst_e;
    logic       we_reg_e;
    logic       alu_src_e;
    logic       we_dm_e;
    logic       dm2reg_e;
    logic [3:0] alu_ctrl_e;
    logic       shmux_e;
    logic       mult_enable_e;
    logic       sfmux_high_e;
    logic       sf2reg_e;

    modport master (
        output opcode, funct, flush_e,
        input  branch, jump, jal, jr, illegal,
        input  reg_dst_e, we_reg_e, alu_src_e, we_dm_e, dm2reg_e, alu_ctrl_e,
        input  shmux_e, mult_enable_e, sfmux_high_e, sf2reg_e
    );

    modport slave (
        input  opcode, funct, flush_e,
        output branch, jump, jal, jr, illegal,
        output reg_dst_e, we_reg_e, alu_src_e, we_dm_e, dm2reg_e, alu_ctrl_e,
        output shmux_e, mult_enable_e, sfmux_high_e, sf2reg_e
    );
endinterface

// File: rtl/mips_ctrl_decoder.sv
// MIPS control decoder: combined main/funct decode, D-stage flags combinational,
// datapath control bundle registered into the E stage with flush.
module mips_ctrl_decoder (
    input logic               clk,
    input logic               rst,
    mips_ctrl_decoder_if.slave bus
);
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluSll = 4'b1000;
    localparam logic [3:0] AluSrl = 4'b1001;

    typedef struct packed {
        logic       reg_dst;
        logic       we_reg;
        logic       alu_src;
        logic       we_dm;
        logic       dm2reg;
        logic [3:0] alu_ctrl;
        logic       shmux;
        logic       mult_enable;
        logic       sfmux_high;
        logic       sf2reg;
    } ctrl_t;

    logic       reg_dst, we_reg, alu_src, we_dm, dm2reg;
    logic [1:0] alu_op;
    logic       branch, jump, jal, illegal_op;

    logic [3:0] alu_ctrl;
    logic       shmux, mult_enable, sfmux_high, sf2reg, jr, illegal_fn, kill_we;

    ctrl_t ctrl_d, ctrl_q;

    always_comb begin
        reg_dst    = 1'b0;
        we_reg     = 1'b0;
        alu_src    = 1'b0;
        we_dm      = 1'b0;
        dm2reg     = 1'b0;
        alu_op     = 2'b00;
        branch     = 1'b0;
        jump       = 1'b0;
        jal        = 1'b0;
        illegal_op = 1'b0;
        unique case (bus.opcode)
            6'b000000: begin reg_dst = 1'b1; we_reg = 1'b1; alu_op = 2'b10; end
            6'b100011: begin we_reg = 1'b1; alu_src = 1'b1; dm2reg = 1'b1; end
            6'b101011: begin alu_src = 1'b1; we_dm = 1'b1; end
            6'b000100: begin alu_op = 2'b01; branch = 1'b1; end
            6'b001000: begin we_reg = 1'b1; alu_src = 1'b1; end
            6'b000010: jump = 1'b1;
            6'b000011: begin we_reg = 1'b1; jump = 1'b1; jal = 1'b1; end
            default:   illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        alu_ctrl    = AluAdd;
        shmux       = 1'b0;
        mult_enable = 1'b0;
        sfmux_high  = 1'b0;
        sf2reg      = 1'b0;
        jr          = 1'b0;
        illegal_fn  = 1'b0;
        kill_we     = 1'b0;
        unique case (alu_op)
            2'b00: alu_ctrl = AluAdd;
            2'b01: alu_ctrl = AluSub;
            2'b10: begin
                unique case (bus.funct)
                    6'b100000: alu_ctrl = AluAdd;
                    6'b100010: alu_ctrl = AluSub;
                    6'b100100: alu_ctrl = AluAnd;
                    6'b100101: alu_ctrl = AluOr;
                    6'b101010: alu_ctrl = AluSlt;
                    6'b000000: begin alu_ctrl = AluSll; shmux = 1'b1; end
                    6'b000010: begin alu_ctrl = AluSrl; shmux = 1'b1; end
                    6'b001000: begin jr = 1'b1; kill_we = 1'b1; end
                    6'b011001: begin mult_enable = 1'b1; kill_we = 1'b1; end
                    6'b010000: begin sf2reg = 1'b1; sfmux_high = 1'b1; end
                    6'b010010: sf2reg = 1'b1;
                    default: begin
                        illegal_fn = 1'b1;
                        kill_we    = 1'b1;
                        alu_ctrl   = AluAnd;
                    end
                endcase
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

    // An unsupported opcode must produce an all-zero bundle, including alu_ctrl.
    always_comb begin
        ctrl_d             = '0;
        ctrl_d.reg_dst     = reg_dst;
        ctrl_d.we_reg      = we_reg & ~kill_we;
        ctrl_d.alu_src     = alu_src;
        ctrl_d.we_dm       = we_dm;
        ctrl_d.dm2reg      = dm2reg;
        ctrl_d.alu_ctrl    = illegal_op ? 4'b0000 : alu_ctrl;
        ctrl_d.shmux       = shmux;
        ctrl_d.mult_enable = mult_enable;
        ctrl_d.sfmux_high  = sfmux_high;
        ctrl_d.sf2reg      = sf2reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (bus.flush_e) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.branch  = branch;
    assign bus.jump    = jump;
    assign bus.jal     = jal;
    assign bus.jr      = jr;
    assign bus.illegal = illegal_op | illegal_fn;

    assign bus.reg_dst_e     = ctrl_q.reg_dst;
    assign bus.we_reg_e      = ctrl_q.we_reg;
    assign bus.alu_src_e     = ctrl_q.alu_src;
    assign bus.we_dm_e       = ctrl_q.we_dm;
    assign bus.dm2reg_e      = ctrl_q.dm2reg;
    assign bus.alu_ctrl_e    = ctrl_q.alu_ctrl;
    assign bus.shmux_e       = ctrl_q.shmux;
    assign bus.mult_enable_e = ctrl_q.mult_enable;
    assign bus.sfmux_high_e  = ctrl_q.sfmux_high;
    assign bus.sf2reg_e      = ctrl_q.sf2reg;
endmodule

// File: tb/tb_mips_ctrl_decoder.sv
// Directed bench for mips_ctrl_decoder: E bundle and D flags against hand-computed vectors.
module tb_mips_ctrl_decoder;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    mips_ctrl_decoder_if bus ();

    mips_ctrl_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // E bundle order: reg_dst we_reg alu_src we_dm dm2reg alu_ctrl[3:0] shmux mult sfhi sf2reg
    function automatic logic [12:0] e_vec();
        return {bus.reg_dst_e, bus.we_reg_e, bus.alu_src_e, bus.we_dm_e, bus.dm2reg_e,
                bus.alu_ctrl_e, bus.shmux_e, bus.mult_enable_e, bus.sfmux_high_e,
                bus.sf2reg_e};
    endfunction

    // D flags order: branch jump jal jr illegal
    function automatic logic [4:0] d_vec();
        return {bus.branch, bus.jump, bus.jal, bus.jr, bus.illegal};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.flush_e = 1'b0;
        drive(6'b100011, 6'b000000);
        #1;
        total_cnt++;
        if (e_vec() !== 13'b0) $display("FAIL reset_async: got %b expected %b", e_vec(), 13'b0);
        else pass_cnt++;
        #2 rst = 1'b0;
        tick();
        total_cnt++;
        if (e_vec() !== 13'b0_1_1_0_1_0010_0000)
            $display("FAIL lw_after_reset: got %b expected %b", e_vec(), 13'b0_1_1_0_1_0010_0000);
        else pass_cnt++;
        bus.flush_e = 1'b1;
        tick();
        total_cnt++;
        if (e_vec() !== 13'b0) $display("FAIL flush: got %b expected %b", e_vec(), 13'b0);
        else pass_cnt++;
        bus.flush_e = 1'b0;
        tick();
        total_cnt++;
        if (e_vec() !== 13'b0_1_1_0_1_0010_0000)
            $display("FAIL reload_after_flush: got %b expected %b", e_vec(),
                     13'b0_1_1_0_1_0010_0000);
        else pass_cnt++;
        // Mid-stream asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (e_vec() !== 13'b0) $display("FAIL reset_midstream: got %b expected %b", e_vec(), 13'b0);
        else pass_cnt++;
        #1 rst = 1'b0;
        tick();
        total_cnt++;
        if (e_vec() !== 13'b0_1_1_0_1_0010_0000)
            $display("FAIL load_after_midreset: got %b expected %b", e_vec(),
                     13'b0_1_1_0_1_0010_0000);
        else pass_cnt++;
    endtask

    task automatic test_rtype_sweep();
        logic [5:0]  fn  [7];
        logic [12:0] exp [7];
        fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
        exp = '{13'b1_1_0_0_0_0010_0000, 13'b1_1_0_0_0_0110_0000, 13'b1_1_0_0_0_0000_0000,
                13'b1_1_0_0_0_0001_0000, 13'b1_1_0_0_0_0111_0000, 13'b1_1_0_0_0_1000_1000,
                13'b1_1_0_0_0_1001_1000};
        for (int i = 0; i < 7; i++) begin
            drive(6'b000000, fn[i]);
            #1;
            total_cnt++;
            if (d_vec() !== 5'b00000)
                $display("FAIL rtype_d[%0d]: got %b expected %b", i, d_vec(), 5'b00000);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (e_vec() !== exp[i])
                $display("FAIL rtype_e[%0d]: got %b expected %b", i, e_vec(), exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_special_rtype();
        logic [5:0]  fn   [4];
        logic [4:0]  dexp [4];
        logic [12:0] eexp [4];
        fn   = '{6'b001000, 6'b011001, 6'b010000, 6'b010010};
        dexp = '{5'b00010, 5'b00000, 5'b00000, 5'b00000};
        eexp = '{13'b1_0_0_0_0_0010_0000, 13'b1_0_0_0_0_0010_0100,
                 13'b1_1_0_0_0_0010_0011, 13'b1_1_0_0_0_0010_0001};
        for (int i = 0; i < 4; i++) begin
            drive(6'b000000, fn[i]);
            #1;
            total_cnt++;
            if (d_vec() !== dexp[i])
                $display("FAIL special_d[%0d]: got %b expected %b", i, d_vec(), dexp[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (e_vec() !== eexp[i])
                $display("FAIL special_e[%0d]: got %b expected %b", i, e_vec(), eexp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_branch_jump_mem();
        logic [5:0]  op   [5];
        logic [4:0]  dexp [5];
        logic [12:0] eexp [5];
        // beq, j, jal, sw, addi; funct=100100 everywhere to show it is ignored
        op   = '{6'b000100, 6'b000010, 6'b000011, 6'b101011, 6'b001000};
        dexp = '{5'b10000, 5'b01000, 5'b01100, 5'b00000, 5'b00000};
        eexp = '{13'b0_0_0_0_0_0110_0000, 13'b0_0_0_0_0_0010_0000, 13'b0_1_0_0_0_0010_0000,
                 13'b0_0_1_1_0_0010_0000, 13'b0_1_1_0_0_0010_0000};
        for (int i = 0; i < 5; i++) begin
            drive(op[i], 6'b100100);
            #1;
            total_cnt++;
            if (d_vec() !== dexp[i])
                $display("FAIL brjmem_d[%0d]: got %b expected %b", i, d_vec(), dexp[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (e_vec() !== eexp[i])
                $display("FAIL brjmem_e[%0d]: got %b expected %b", i, e_vec(), eexp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        drive(6'b111111, 6'b100000);
        #1;
        total_cnt++;
        if (d_vec() !== 5'b00001) $display("FAIL illegal_op_d: got %b expected %b", d_vec(), 5'b00001);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (e_vec() !== 13'b0) $display("FAIL illegal_op_e: got %b expected %b", e_vec(), 13'b0);
        else pass_cnt++;
        drive(6'b000000, 6'b111111);
        #1;
        total_cnt++;
        if (d_vec() !== 5'b00001) $display("FAIL illegal_fn_d: got %b expected %b", d_vec(), 5'b00001);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.we_reg_e, bus.alu_ctrl_e} !== 5'b0_0000)
            $display("FAIL illegal_fn_e: got %b expected %b", {bus.we_reg_e, bus.alu_ctrl_e},
                     5'b0_0000);
        else pass_cnt++;
    endtask

    task automatic test_flush_priority();
        drive(6'b000000, 6'b100000);
        bus.flush_e = 1'b1;
        tick();
        total_cnt++;
        if (e_vec() !== 13'b0) $display("FAIL flush_priority: got %b expected %b", e_vec(), 13'b0);
        else pass_cnt++;
        bus.flush_e = 1'b0;
        tick();
        total_cnt++;
        if (e_vec() !== 13'b1_1_0_0_0_0010_0000)
            $display("FAIL after_flush_add: got %b expected %b", e_vec(), 13'b1_1_0_0_0_0010_0000);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_rtype_sweep();
        test_special_rtype();
        test_branch_jump_mem();
        test_illegal();
        test_flush_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
